// File: rtl/mips_muldiv_alu.sv
// EX-stage ALU with a start/busy/done handshake. Logic, arithmetic and compare ops finish in one cycle.
// Unsigned shift-add multiply and restoring divide take one cycle per bit and write the HI/LO registers.
module mips_muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_EQ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
  logic [WIDTH-1:0] out_reg, hi_reg, lo_reg;
  logic             zero_reg, done_reg;

  logic             accept;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;
  logic             last_iter;

  assign accept    = start && (state_reg == IDLE);
  assign last_iter = (count_reg == CW'(1));

  // Single-cycle result path
  always_comb begin
    alu_out  = '0;
    alu_zero = 1'b1;
    case (op)
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  alu_out = ~(a | b);
      OP_MFHI: alu_out = hi_reg;
      OP_MFLO: alu_out = lo_reg;
      default: alu_out = '0;
    endcase
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLTU, OP_NOR, OP_MFHI, OP_MFLO:
        alu_zero = (alu_out == '0);
      OP_EQ:   alu_zero = (a == b);
      default: alu_zero = 1'b1;
    endcase
  end

  // One iteration step; acc_lo holds the multiplier (MUL) or dividend/quotient (DIV)
  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opnd_reg};
    div_ok      = ~div_diff[WIDTH];
    div_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_next = {acc_lo_reg[WIDTH-2:0], div_ok};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && op == OP_MULTU)                state_next = MUL;
        else if (accept && op == OP_DIVU && b != '0) state_next = DIV;
      end
      MUL, DIV: if (last_iter) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      out_reg    <= '0;
      zero_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (accept) begin
        if (op == OP_MULTU) begin
          acc_hi_reg <= '0;
          acc_lo_reg <= b;
          opnd_reg   <= a;
          count_reg  <= CW'(WIDTH);
        end else if (op == OP_DIVU) begin
          if (b == '0) begin
            hi_reg   <= a;
            lo_reg   <= '1;
            done_reg <= 1'b1;
          end else begin
            acc_hi_reg <= '0;
            acc_lo_reg <= a;
            opnd_reg   <= b;
            count_reg  <= CW'(WIDTH);
          end
        end else begin
          out_reg  <= alu_out;
          zero_reg <= alu_zero;
          done_reg <= 1'b1;
        end
      end else if (state_reg == MUL || state_reg == DIV) begin
        count_reg  <= count_reg - CW'(1);
        acc_hi_reg <= (state_reg == MUL) ? mul_hi_next : div_hi_next;
        acc_lo_reg <= (state_reg == MUL) ? mul_lo_next : div_lo_next;
        if (last_iter) begin
          hi_reg   <= (state_reg == MUL) ? mul_hi_next : div_hi_next;
          lo_reg   <= (state_reg == MUL) ? mul_lo_next : div_lo_next;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign out  = out_reg;
  assign zero = zero_reg;
  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: doc/mips_muldiv_alu.md
# mips_muldiv_alu

Parametrised, clocked successor to the single-cycle MIPS ALU. It keeps the existing logic, arithmetic and compare operation encodings, and adds iterative unsigned multiply and divide into HI/LO registers, plus MFHI/MFLO reads. Every operation uses a start/busy/done handshake, so the control unit can stall the pipeline during multi-cycle operations. It sits in the EX stage, replacing the combinational ALU.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A, sampled only on an accepted start.
- b  in  WIDTH  operand B, sampled only on an accepted start.
- op  in  4  operation code, sampled only on an accepted start.
- start  in  1  request; accepted when start=1 and busy=0.
- out  out  WIDTH  registered result.
- zero  out  1  registered flag.
- busy  out  1  high while a MULTU/DIVU iterates.
- done  out  1  one-cycle pulse when out/zero/hi/lo are updated.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Single-cycle ops, writing out on completion:
  - 0000 AND, out=a&b.
  - 0001 OR, out=a|b.
  - 0010 ADD, out=a+b mod 2^WIDTH, carry dropped.
  - 0110 SUB, out=a-b mod 2^WIDTH.
  - 0111 SLTU, out=1 if a<b unsigned, else 0.
  - 1100 NOR, out=~(a|b).
  - 1010 MFHI, out=hi.
  - 1011 MFLO, out=lo.
- For all of the above, zero=(out==0).
- 0101 EQ: out=0, zero=(a==b).
- Multi-cycle ops; these leave out and zero unchanged:
  - 1000 MULTU: {hi,lo} = a*b, a 2·WIDTH-bit unsigned product computed by shift-add, one partial product per cycle.
  - 1001 DIVU: lo=a/b, hi=a%b, unsigned, restoring division, one quotient bit per cycle.
- Divide by zero: b==0 is detected on the start cycle and no iteration runs. The op completes as a single-cycle op with lo=all ones and hi=a.
- Any other op code: out=0, zero=1, single-cycle completion.
- FSM states:
  - IDLE: on accepted MULTU/DIVU with a legal divisor, latch a, b and op, load iteration counter with WIDTH, then go to MUL or DIV.
  - MUL/DIV: one iteration per cycle, counter decrements. When counter reaches 0, write hi/lo, pulse done, return to IDLE.
  - Single-cycle ops never leave IDLE.
- start while busy=1 is ignored: no latch, no done. The requester must hold start until it is accepted.
- hi/lo change only on MULTU/DIVU completion, divide by zero, or reset.

## Timing
- Reset values: out=0, zero=0, hi=0, lo=0, busy=0, done=0, state IDLE, counter=0.
- Reset asserted mid-operation aborts it: no done pulse, hi/lo cleared to 0 on that edge.
- Single-cycle op: start accepted at edge N. out and zero are valid and done=1 after edge N+1. busy stays 0.
- MULTU / DIVU with legal divisor, start accepted at edge N:
  - busy=1 after edges N+1 through N+WIDTH.
  - hi/lo are written and done=1 after edge N+WIDTH+1, with busy=0 on the same cycle.
  - Total latency is WIDTH+1 cycles.
- done is high for exactly one cycle per accepted op.
- Back-to-back issue: in the done cycle busy=0, so a new start on that cycle is accepted and done may assert again on the next cycle.
- An MFHI/MFLO issued in the done cycle of a MULTU/DIVU reads the new hi/lo.
- Operands changing while busy do not affect the result.

## Test plan
- Reset, then ADD a=7, b=5: out=12, zero=0, done pulses 1 cycle after start, busy never set.
- SUB a=5, b=5: out=0, zero=1. Then EQ a=9, b=9: out=0, zero=1. Then SLTU a=3, b=0xFFFFFFFF: out=1, zero=0.
- MULTU a=0xFFFFFFFF, b=2: busy for 32 cycles, done at cycle 33, hi=0x00000001, lo=0xFFFFFFFE. MFHI issued in the done cycle returns out=1 one cycle later.
- DIVU a=100, b=7: lo=14, hi=2 after 33 cycles. DIVU a=100, b=0: done after 1 cycle, lo=0xFFFFFFFF, hi=100, busy never set.
- During a MULTU, pulse start with ADD and change a/b: no extra done, and the product uses the original operands.
- Assert rst for one cycle at iteration 10 of a DIVU: busy=0, done=0, hi=lo=out=0 after the reset edge. A subsequent ADD 1+1 gives out=2.
